// File: rtl/uart_tx_if.sv
// ============================================================================
// uart_tx_if : host-side byte handshake (valid/ready) for the UART transmitter
// Revision   : 1.0
// ============================================================================
`default_nettype none

interface uart_tx_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;

  modport master (output data_in, output valid_in, input ready_out);
  modport slave  (input data_in, input valid_in, output ready_out);
endinterface

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// uart_tx : 8N1 serialiser, OS ticks per bit cell, buffered valid/ready input
//           UART_TX_FIFO_EN selects a DEPTH-entry FIFO instead of one register
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx #(
  parameter int OS    = 16,
  parameter int DEPTH = 4
) (
  input  wire logic CLK,
  input  wire logic rst_n,
  input  wire logic os_tick,
  uart_tx_if.slave  host,
  output logic      TX,
  output logic      busy,
  output logic      done_out
);

  localparam int CW = $clog2(OS);
  localparam logic [CW-1:0] OS_LAST = CW'(OS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  if (OS < 2) begin : g_bad_os
    $error("uart_tx: OS must be >= 2");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx: DEPTH must be a power of 2, >= 2");
  end

  logic       push;
  logic       pop;
  logic       buf_empty;
  logic [7:0] buf_data;

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Fullness comes from the registered count, so a pop cannot admit a push
  // in the same cycle.
  assign host.ready_out = (count_q != FULL);
  assign push           = host.valid_in && host.ready_out;
  assign buf_empty      = (count_q == '0);
  assign buf_data       = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = host.data_in;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
`else
  logic [7:0] hold_q, hold_d;
  logic       hold_valid_q, hold_valid_d;

  assign host.ready_out = !hold_valid_q;
  assign push           = host.valid_in && !hold_valid_q;
  assign buf_empty      = !hold_valid_q;
  assign buf_data       = hold_q;

  // push needs an empty holder and pop a full one, so they never coincide
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (push) begin
      hold_d       = host.data_in;
      hold_valid_d = 1'b1;
    end else if (pop) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end
`endif

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] os_cnt_q, os_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_idx_d = bit_idx_q;
    sh_d      = sh_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    if (os_tick) begin
      if ((state_q != S_IDLE) && (os_cnt_q != '0)) begin
        os_cnt_d = os_cnt_q - 1'b1;
      end else begin
        case (state_q)
          S_START: begin
            tx_d      = sh_q[0];
            bit_idx_d = 3'd0;
            os_cnt_d  = OS_LAST;
            state_d   = S_DATA;
          end
          S_DATA: begin
            os_cnt_d = OS_LAST;
            if (bit_idx_q == 3'd7) begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end else begin
              sh_d      = {1'b0, sh_q[7:1]};
              tx_d      = sh_q[1];
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end
          default: begin
            // S_IDLE start, or S_STOP end with the next start chained in
            if (state_q == S_STOP) done_d = 1'b1;
            if (!buf_empty) begin
              pop      = 1'b1;
              sh_d     = buf_data;
              tx_d     = 1'b0;
              os_cnt_d = OS_LAST;
              state_d  = S_START;
            end else begin
              state_d  = S_IDLE;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      os_cnt_q  <= '0;
      bit_idx_q <= '0;
      sh_q      <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_idx_q <= bit_idx_d;
      sh_q      <= sh_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign TX       = tx_q;
  assign busy     = (state_q != S_IDLE);
  assign done_out = done_q;

endmodule

`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

Transmit half of the UART link. Pairs with the 16× oversampling receiver on the same `os_tick` baud generator. Accepts bytes from the host side over a valid/ready handshake, buffers them, and serialises each as an 8N1 frame (start, 8 data bits LSB first, 1 stop) on `TX`. Every bit cell lasts exactly `OS` oversample ticks, so one shared tick generator serves both directions.

## Interface
- `OS`, default 16: `os_tick` pulses per bit cell; must be ≥ 2.
- `DEPTH`, default 4: input FIFO entries; power of 2, ≥ 2. Used only when `UART_TX_FIFO_EN` is defined.

Ports. Reset is asynchronous and active-low.
- `CLK` input, 1 bit: system clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `os_tick` input, 1 bit: one-`CLK` pulse at 16× baud.
- `data_in` input, 8 bits: byte to send.
- `valid_in` input, 1 bit: `data_in` is valid.
- `ready_out` output, 1 bit: block can accept a byte this cycle.
- `TX` output, 1 bit: serial line, idle high; registered.
- `busy` output, 1 bit: a frame is in progress (state ≠ S_IDLE).
- `done_out` output, 1 bit: one-`CLK` pulse when a stop bit completes.

## Operation
- **Accept:** a byte is accepted on a `CLK` edge where `valid_in && ready_out`.
  - `valid_in` while `ready_out`=0 is ignored; the host holds it.
  - `data_in` is sampled only on accept.
- **Buffer:** the FIFO stores accepted bytes in order. `ready_out = !full`, driven from registered state.
  - A push while full is rejected, even if a pop happens in the same cycle.
  - A push and a pop in the same cycle when not full: occupancy is unchanged.
- **FSM states:** S_IDLE, S_START, S_DATA, S_STOP. The FSM advances only on `CLK` edges where `os_tick`=1. There is a bit counter `os_cnt` (width `$clog2(OS)`) and a bit index `bit_idx` (3 bits).
- **S_IDLE** (`TX`=1):
  - On `os_tick` with buffer non-empty: pop into shift register `sh`, set `TX`←0, `os_cnt`←OS-1, go to S_START.
  - If the buffer is empty: stay in S_IDLE.
- **Rule in every other state:** on `os_tick`, if `os_cnt`≠0 then decrement; otherwise apply the state's exit action below.
- **S_START exit:** `TX`←`sh[0]`, `bit_idx`←0, `os_cnt`←OS-1, go to S_DATA.
- **S_DATA exit:**
  - If `bit_idx`=7: `TX`←1, go to S_STOP.
  - Otherwise: shift `sh` right, `TX`←next bit, increment `bit_idx`.
  - In both cases `os_cnt`←OS-1.
- **S_STOP exit:**
  - Pulse `done_out`.
  - If the buffer is non-empty: pop, `TX`←0, `os_cnt`←OS-1, go to S_START. Frames are sent back-to-back with no idle cell.
  - Otherwise go to S_IDLE.
- **Line rules:**
  - `TX` changes only on `os_tick` edges.
  - No glitches: `TX` is driven from a flop, never from combinational logic.

## Timing
- **Reset values:** `TX`=1, `ready_out`=1, `busy`=0, `done_out`=0. Also FIFO empty, state S_IDLE, `os_cnt`=0, `bit_idx`=0, `sh`=0.
- **Reset mid-frame:** `TX` returns to 1 asynchronously. The FIFO contents are discarded and the partial frame is abandoned. After deassertion the block resumes from S_IDLE.
- **Latency:**
  - From accept at edge N, `TX` falls on the first `os_tick` edge later than N. No frame starts on edge N itself, because the FIFO write is visible from N+1.
  - `ready_out` falls the cycle after the accept that fills the FIFO.
- **Bit cell:** each bit is `OS` `os_tick` periods long. A full frame is 10·OS ticks, i.e. 160 at OS=16.
- **`done_out`:** asserted for exactly one `CLK`, on the `os_tick` edge that ends the stop bit.
- **`busy`:** high from the start-bit edge until the stop-bit end edge; low for ≥1 `CLK` only if the buffer is empty at that edge.
- **No ticks:** if `os_tick` stays low, the FSM and `TX` hold indefinitely; the handshake still runs.

## Configuration
- **`UART_TX_FIFO_EN` defined:** a DEPTH-entry circular FIFO with wrapping read/write pointers and a `$clog2(DEPTH)+1`-bit count. `ready_out` stays high until DEPTH bytes are pending.
- **Not defined:** a single holding register replaces the FIFO and `DEPTH` is ignored.
  - `ready_out` = !hold_valid.
  - The holding register frees on the pop at a frame start, so one byte can queue behind the frame in flight.
  - All frame timing is identical in both builds.

## Test plan
- **Single frame:** OS=16, `os_tick` every 4 `CLK`, send 0x55 → `TX` low for 16 ticks, then 1,0,1,0,1,0,1,0 at 16 ticks each, then stop high for 16 ticks. One `done_out` pulse; `busy` low afterwards.
- **Back-to-back:** send 0xA5 then 0x3C back-to-back → the second start bit begins on the same edge the first stop bit ends. No high gap beyond 16 ticks; two `done_out` pulses 160 ticks apart.
- **FIFO full (`UART_TX_FIFO_EN`, DEPTH=4):** `os_tick` held low, push 0x01–0x04 → `ready_out`=0 after the 4th accept. A 5th byte (0x05) is not accepted until the first pop. Output order is 0x01..0x05.
- **Macro undefined:** push 0x11 and 0x22 while idle → 0x11 starts, 0x22 is held, and `ready_out` stays 0 until 0x22 starts transmitting.
- **Reset mid-frame:** assert `rst_n`=0 mid-data-bit of 0xF0 with 2 bytes queued → `TX`=1 immediately and `busy`=0. After release there are no further frames and `ready_out`=1.
- **Stalled ticks:** hold `os_tick` low for 1000 `CLK` mid-bit → `TX` is stable, and the cell resumes with its remaining tick count intact.
